// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a memory watchdog.
// Optional performance counters are enabled by defining CORE_SEQ_PERF_EN.
module core_sequencer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            imem_req,
   input  logic            imem_ready,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ready,
   input  logic            dec_reg_write,
   input  logic            dec_mem_read,
   input  logic            dec_mem_write,
   input  logic            dec_is_branch,
   input  logic            dec_is_jump,
   output logic            ir_load,
   output logic            ex_en,
   output logic            rf_write,
   output logic            pc_update,
   output logic            retired,
   output logic [2:0]      state,
   output logic            fault,
   output logic [XLEN-1:0] cycle_count,
   output logic [XLEN-1:0] instret_count
);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StFetch     = 3'd1;
   localparam logic [2:0] StDecode    = 3'd2;
   localparam logic [2:0] StExecute   = 3'd3;
   localparam logic [2:0] StMemory    = 3'd4;
   localparam logic [2:0] StWriteback = 3'd5;
   localparam logic [2:0] StFault     = 3'd6;

   localparam logic [15:0] TimeoutLim = TIMEOUT[15:0];
   localparam bit          WatchdogEn = (TIMEOUT != 0);

   logic [2:0]  state_q, state_d;
   logic [15:0] wait_q, wait_d;
   logic        timeout_hit;
   logic        waiting;

   // Branch/jump resolution lives in the external PC mux; the sequence ignores them.
   logic unused_dec;
   assign unused_dec = dec_is_branch ^ dec_is_jump;

   assign timeout_hit = WatchdogEn && (wait_q == TimeoutLim);
   assign waiting     = ((state_q == StFetch) && !imem_ready) ||
                        ((state_q == StMemory) && !dmem_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:      if (run) state_d = StFetch;
         StFetch: begin
            if (imem_ready)       state_d = StDecode;
            else if (timeout_hit) state_d = StFault;
         end
         StDecode:    state_d = StExecute;
         StExecute:   state_d = (dec_mem_read || dec_mem_write) ? StMemory : StWriteback;
         StMemory: begin
            if (dmem_ready)       state_d = StWriteback;
            else if (timeout_hit) state_d = StFault;
         end
         StWriteback: state_d = run ? StFetch : StIdle;
         StFault:     state_d = StFault;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMemory))) begin
         wait_d = '0;
      end else if (waiting && (wait_q != 16'hFFFF)) begin
         // Saturate so a disabled watchdog never wraps back through small values.
         wait_d = wait_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign state     = state_q;
   assign imem_req  = (state_q == StFetch);
   assign ir_load   = (state_q == StFetch) && imem_ready;
   assign ex_en     = (state_q == StExecute);
   assign dmem_req  = (state_q == StMemory);
   assign dmem_we   = (state_q == StMemory) && dec_mem_write;
   assign rf_write  = (state_q == StWriteback) && dec_reg_write;
   assign pc_update = (state_q == StWriteback);
   assign retired   = (state_q == StWriteback);
   assign fault     = (state_q == StFault);

`ifdef CORE_SEQ_PERF_EN
   logic [XLEN-1:0] cycle_q, instret_q;
   logic            active;

   assign active = (state_q >= StFetch) && (state_q <= StWriteback);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (active)  cycle_q   <= cycle_q + XLEN'(1);
         if (retired) instret_q <= instret_q + XLEN'(1);
      end
   end

   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`else
   assign cycle_count   = '0;
   assign instret_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer (watchdog limit set to 4 cycles).
module tb_core_sequencer;

   localparam int unsigned XLEN = 32;

   // Packed observation: bit flags plus the state code in [2:0].
   localparam logic [11:0] IMREQ = 12'h800;
   localparam logic [11:0] DREQ  = 12'h400;
   localparam logic [11:0] DWE   = 12'h200;
   localparam logic [11:0] IRLD  = 12'h100;
   localparam logic [11:0] EXEN  = 12'h080;
   localparam logic [11:0] RFW   = 12'h040;
   localparam logic [11:0] PCU   = 12'h020;
   localparam logic [11:0] RET   = 12'h010;
   localparam logic [11:0] FLT   = 12'h008;

   logic clk = 1'b0;
   logic rst;
   logic run, imem_ready, dmem_ready;
   logic dec_reg_write, dec_mem_read, dec_mem_write, dec_is_branch, dec_is_jump;
   logic imem_req, dmem_req, dmem_we, ir_load, ex_en, rf_write, pc_update, retired, fault;
   logic [2:0]      state;
   logic [XLEN-1:0] cycle_count, instret_count;
   logic [11:0]     obs;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign obs = {imem_req, dmem_req, dmem_we, ir_load, ex_en, rf_write, pc_update, retired,
                 fault, state};

   core_sequencer #(.XLEN(XLEN), .TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .imem_req      (imem_req),
      .imem_ready    (imem_ready),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_ready    (dmem_ready),
      .dec_reg_write (dec_reg_write),
      .dec_mem_read  (dec_mem_read),
      .dec_mem_write (dec_mem_write),
      .dec_is_branch (dec_is_branch),
      .dec_is_jump   (dec_is_jump),
      .ir_load       (ir_load),
      .ex_en         (ex_en),
      .rf_write      (rf_write),
      .pc_update     (pc_update),
      .retired       (retired),
      .state         (state),
      .fault         (fault),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );

   task automatic set_dec(input logic rw, input logic mr, input logic mw, input logic br,
                          input logic jp);
      dec_reg_write = rw;
      dec_mem_read  = mr;
      dec_mem_write = mw;
      dec_is_branch = br;
      dec_is_jump   = jp;
   endtask

   // Leaves the bench at a falling edge with the DUT idle and rst released.
   task automatic do_reset();
      rst = 1'b1;
      {run, imem_ready, dmem_ready} = 3'b000;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {run, imem_ready, dmem_ready} = 3'b111;
      set_dec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
      end
      checks++;
      if (cycle_count !== '0 || instret_count !== '0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count);
      end
   endtask

   task automatic test_alu();
      logic [2:0]  in_v [6] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100};
      logic [11:0] ex_v [6] = '{12'h000, IMREQ | IRLD | 12'd1, 12'd2, EXEN | 12'd3,
                                RFW | PCU | RET | 12'd5, IMREQ | 12'd1};
      do_reset();
      set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL alu cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
   endtask

   task automatic test_load_wait();
      logic [2:0]  in_v [10] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b001, 3'b000, 3'b000};
      logic [11:0] ex_v [10] = '{12'h000, IMREQ | IRLD | 12'd1, 12'd2, EXEN | 12'd3,
                                 DREQ | 12'd4, DREQ | 12'd4, DREQ | 12'd4, DREQ | 12'd4,
                                 RFW | PCU | RET | 12'd5, 12'h000};
      do_reset();
      set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL load_wait cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
   endtask

   // Both mem flags set (store wins); ready arrives exactly when the wait count hits the limit.
   task automatic test_store_limit();
      logic [2:0]  in_v [11] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b100, 3'b001, 3'b000, 3'b000};
      logic [11:0] ex_v [11] = '{12'h000, IMREQ | IRLD | 12'd1, 12'd2, EXEN | 12'd3,
                                 DREQ | DWE | 12'd4, DREQ | DWE | 12'd4, DREQ | DWE | 12'd4,
                                 DREQ | DWE | 12'd4, DREQ | DWE | 12'd4, PCU | RET | 12'd5,
                                 12'h000};
      do_reset();
      set_dec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL store_limit cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
   endtask

   task automatic test_fetch_timeout();
      logic [2:0]  in_v [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b000, 3'b100, 3'b000, 3'b111};
      logic [11:0] ex_v [10] = '{12'h000, IMREQ | 12'd1, IMREQ | 12'd1, IMREQ | 12'd1,
                                 IMREQ | 12'd1, IMREQ | 12'd1, FLT | 12'd6, FLT | 12'd6,
                                 FLT | 12'd6, FLT | 12'd6};
      do_reset();
      set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL fetch_timeout cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
   endtask

   task automatic test_run_drop();
      logic [2:0]  in_v [7] = '{3'b100, 3'b110, 3'b100, 3'b000, 3'b000, 3'b010, 3'b010};
      logic [11:0] ex_v [7] = '{12'h000, IMREQ | IRLD | 12'd1, 12'd2, EXEN | 12'd3,
                                PCU | RET | 12'd5, 12'h000, 12'h000};
      do_reset();
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL run_drop cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
   endtask

   task automatic test_reset_in_memory();
      logic [2:0]  in_v [5] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100};
      logic [11:0] ex_v [5] = '{12'h000, IMREQ | IRLD | 12'd1, 12'd2, EXEN | 12'd3,
                                DREQ | DWE | 12'd4};
      do_reset();
      set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         {run, imem_ready, dmem_ready} = in_v[i];
         #1;
         checks++;
         if (obs !== ex_v[i]) begin
            errors++;
            $display("FAIL rst_mem cycle %0d: got %h expected %h", i, obs, ex_v[i]);
         end
      end
      #1;
      rst = 1'b1;
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== 12'h000) begin
         errors++;
         $display("FAIL rst_mem_async: got %h expected %h", obs, 12'h000);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (obs !== 12'h000) begin
            errors++;
            $display("FAIL rst_mem_hold %0d: got %h expected %h", i, obs, 12'h000);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_counters();
      logic [11:0]     ex;
      logic [XLEN-1:0] exp_cyc, exp_ret;
      do_reset();
      set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= 13; i++) begin
         @(negedge clk);
         run        = (i < 12);
         imem_ready = (i % 4 == 1);
         dmem_ready = 1'b0;
         #1;
         if (i == 0 || i == 13) ex = 12'h000;
         else begin
            case ((i - 1) % 4)
               0:       ex = IMREQ | IRLD | 12'd1;
               1:       ex = 12'd2;
               2:       ex = EXEN | 12'd3;
               default: ex = RFW | PCU | RET | 12'd5;
            endcase
         end
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, ex);
         end
         if (i == 5 || i == 13) begin
`ifdef CORE_SEQ_PERF_EN
            exp_cyc = (i == 5) ? XLEN'(4) : XLEN'(12);
            exp_ret = (i == 5) ? XLEN'(1) : XLEN'(3);
`else
            exp_cyc = '0;
            exp_ret = '0;
`endif
            checks++;
            if (cycle_count !== exp_cyc) begin
               errors++;
               $display("FAIL cycle_count at %0d: got %0d expected %0d", i, cycle_count, exp_cyc);
            end
            checks++;
            if (instret_count !== exp_ret) begin
               errors++;
               $display("FAIL instret_count at %0d: got %0d expected %0d", i, instret_count,
                        exp_ret);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store_limit();
      test_fetch_timeout();
      test_run_drop();
      test_reset_in_memory();
      test_counters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the non-pipelined core: sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction and data memories. It consumes the decoder's control outputs (reg_write, mem_read, mem_write, is_branch, is_link_and_jump) and produces the per-stage enables: instruction-register load, PC update, register-file write, memory requests. A wait-state watchdog drives a sticky fault when a memory never answers.

## Interface
- XLEN, 32, width of the performance counters
- TIMEOUT, 255, max wait cycles per memory request before fault; 0 disables the watchdog
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  allow new instructions; sampled in IDLE and at WRITEBACK exit
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- dmem_ready  in  1  data access complete this cycle
- dec_reg_write, dec_mem_read, dec_mem_write, dec_is_branch, dec_is_jump  in  1 each  decoder control outputs
- ir_load  out  1  latch instruction register
- ex_en  out  1  execute-stage enable (ALU/branch compare)
- rf_write  out  1  register-file write enable
- pc_update  out  1  commit next PC
- retired  out  1  one-cycle pulse per completed instruction
- state  out  3  current state encoding
- fault  out  1  sticky watchdog fault
- cycle_count, instret_count  out  XLEN each  performance counters

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6. Encodings 7 and above recover to IDLE.
- IDLE: all strobes low. run=1 moves to FETCH.
- FETCH: imem_req=1. imem_ready=1 moves to DECODE, and ir_load=1 in that same cycle.
- DECODE: one cycle, no strobes. The decoder settles from the IR.
- EXECUTE: ex_en=1 for one cycle. dec_mem_read or dec_mem_write moves to MEMORY; otherwise to WRITEBACK.
- MEMORY: dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ready. If both mem flags are set, store wins. dmem_ready moves to WRITEBACK.
- WRITEBACK: one cycle with rf_write=dec_reg_write, pc_update=1 and retired=1. Next state is FETCH if run=1, else IDLE.
- dec_is_branch and dec_is_jump do not alter the sequence. The PC mux outside the block resolves them; pc_update commits whichever PC it selects.
- Decoder inputs are read live. They must stay stable from DECODE through WRITEBACK.
- Watchdog:
  - 16-bit wait counter, cleared on entry to FETCH or MEMORY.
  - Increments each cycle the ready input is low.
  - Counter == TIMEOUT with ready still low moves to FAULT.
  - Ready in the same cycle the limit is reached wins.
- FAULT: fault=1, all strobes low, sticky until rst. run is ignored.
- run deasserted mid-instruction does not abort it: the instruction completes, then the FSM goes to IDLE.

## Timing
- Reset value of every output is 0; state=IDLE; counters 0. Reset mid-instruction aborts with no strobe emitted.
- Registers: state, wait counter, counters. Outputs are Moore from state, except ir_load (FETCH & imem_ready).
- Zero-wait memories:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load or store: 5 cycles.
  - Each memory wait cycle adds 1.
- retired pulses at most once per 4 cycles.
- A back-to-back instruction's FETCH starts the cycle after WRITEBACK.

## Configuration
- CORE_SEQ_PERF_EN defined:
  - cycle_count increments every cycle state is not IDLE or FAULT.
  - instret_count increments on retired.
  - Both wrap modulo 2^XLEN and freeze in FAULT.
- Not defined: both counter ports are tied to 0 and no counter flops exist.

## Test plan
- Zero-wait ALU instruction, run held 1 → state 1,2,3,5,1; retired and rf_write high in cycle 4; ir_load in cycle 1.
- Load with dmem_ready delayed 3 cycles → MEMORY held 4 cycles with dmem_we=0; retired in cycle 8; store variant gives dmem_we=1 and rf_write=0.
- TIMEOUT=4, imem_ready stuck 0 → FAULT entered after 5 FETCH cycles; fault=1 until rst; run toggling has no effect.
- run dropped during EXECUTE → instruction retires, then state=0 with no further imem_req.
- rst asserted in MEMORY → state 0 and all outputs 0 immediately (asynchronous), with no pc_update.
- With CORE_SEQ_PERF_EN, 3 zero-wait ALU instructions → cycle_count=12, instret_count=3; without the macro, both read 0.
